// File: rtl/median_pkg.sv
// median_pkg: shared FSM state type and latency helper for the streaming median engine.
package median_pkg;
  typedef enum logic [1:0] {LOAD, SORT, OUT} med_state_t;
  function automatic int med_latency(int n);
    return n * (n + 1) / 2;
  endfunction
endpackage

// File: rtl/median_stream_if.sv
// median_stream_if: sample-in and median-out valid/ready streams of the median engine.
interface median_stream_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave  (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/med_minmax.sv
// med_minmax: combinational compare element; signed when MEDIAN_SIGNED_EN is defined, ties keep B as max.
module med_minmax #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] MAX,
  output logic [WIDTH-1:0] MIN
);
  logic gt;
`ifdef MEDIAN_SIGNED_EN
  assign gt = $signed(A) > $signed(B);
`else
  assign gt = A > B;
`endif
  assign MAX = gt ? A : B;
  assign MIN = gt ? B : A;
endmodule

// File: rtl/median_stream.sv
// median_stream: windowed streaming median via repeated max-extraction passes; MEDIAN_SIGNED_EN selects signed data.
module median_stream
  import median_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM   = 9
) (
  input logic           CLK,
  input logic           RST,
  median_stream_if.slave s
);
  localparam int CW = $clog2(NUM + 1);
  localparam int P  = (NUM + 1) / 2;
`ifdef MEDIAN_SIGNED_EN
  localparam logic [WIDTH-1:0] LOW = {1'b1, {(WIDTH-1){1'b0}}};
`else
  localparam logic [WIDTH-1:0] LOW = '0;
`endif
  if (NUM < 3 || NUM > 63 || NUM % 2 == 0) begin : g_bad_num
    $error("median_stream: NUM must be odd in 3..63");
  end
  med_state_t       state;
  logic [WIDTH-1:0] w [NUM];
  logic [WIDTH-1:0] ext, mx, mn, od;
  logic [CW-1:0]    cnt, pass;
  logic             ov, last, shift;
  assign last  = cnt == CW'(NUM - 1);
  assign shift = (state == LOAD && s.in_valid) || state == SORT;
  // Each pass starts from the lowest value, so the slot freed by the pass max is refilled with a value below every sample.
  med_minmax #(.WIDTH(WIDTH)) u_mm (
    .A(w[NUM-1]), .B(cnt == '0 ? LOW : ext), .MAX(mx), .MIN(mn)
  );
  assign s.in_ready  = state == LOAD;
  assign s.out_data  = od;
  assign s.out_valid = ov;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= LOAD;
      cnt   <= '0;
      pass  <= '0;
      ext   <= '0;
      od    <= '0;
      ov    <= 1'b0;
      for (int i = 0; i < NUM; i++) w[i] <= '0;
    end else begin
      if (shift) begin
        w[0] <= state == LOAD ? s.in_data : mn;
        for (int i = 1; i < NUM; i++) w[i] <= w[i-1];
        cnt <= last ? '0 : cnt + 1'b1;
      end
      case (state)
        LOAD: if (s.in_valid && last) begin
          state <= SORT;
          pass  <= '0;
        end
        SORT: begin
          ext <= mx;
          if (last) begin
            pass <= pass + 1'b1;
            if (pass == CW'(P - 1)) begin
              od    <= mx;
              ov    <= 1'b1;
              state <= OUT;
            end
          end
        end
        OUT: if (s.out_ready) begin
          ov    <= 1'b0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_median_stream.sv
// tb_median_stream: randomized scoreboard bench for median_stream against a sort-based median model.
module tb_median_stream;
  import median_pkg::*;
  localparam int NUM = 9;
  localparam int LAT = med_latency(NUM);
  typedef struct { logic [7:0] d; int at; } exp_t;
  logic clk = 0, rst = 1;
  median_stream_if #(.WIDTH(8)) bus ();
  median_stream #(.WIDTH(8), .NUM(NUM)) dut (.CLK(clk), .RST(rst), .s(bus));
  always #5 clk = ~clk;
  int cyc = 0, total = 0, passed = 0, outs = 0;
  bit bp_rand = 0;
  exp_t eq[$];
  logic [7:0] wq[$];
  logic [7:0] cur [NUM];
  function automatic void chk(bit ok, string name, int act, int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
  endfunction
  function automatic logic [7:0] median(logic [7:0] q[$]);
    int v[$];
    foreach (q[i]) begin
`ifdef MEDIAN_SIGNED_EN
      v.push_back(int'($signed(q[i])));
`else
      v.push_back(int'(q[i]));
`endif
    end
    v.sort();
    return 8'(v[NUM/2]);
  endfunction
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin @(posedge clk); #1; if (bp_rand) bus.out_ready = 1'($urandom_range(0, 1)); end
  // Scoreboard monitor, sampling on the falling edge.
  initial begin
    bit prev_v = 0, prev_hs = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wq.delete(); eq.delete(); prev_v = 0; prev_hs = 0;
        continue;
      end
      if (bus.in_valid && bus.in_ready) begin
        wq.push_back(bus.in_data);
        if (wq.size() == NUM) begin
          eq.push_back('{median(wq), cyc + 1 + LAT});
          wq.delete();
        end
      end
      if (prev_hs) chk(!bus.out_valid, "one_cycle_valid", int'(bus.out_valid), 0);
      if (bus.out_valid) begin
        chk(!bus.in_ready, "in_ready_in_out", int'(bus.in_ready), 0);
        if (eq.size() == 0) chk(0, "spurious_out_valid", 1, 0);
        else begin
          if (!prev_v) chk(cyc == eq[0].at, "latency", cyc, eq[0].at);
          chk(bus.out_data == eq[0].d, "median", int'(bus.out_data), int'(eq[0].d));
          if (bus.out_ready) begin void'(eq.pop_front()); outs++; end
        end
      end
      prev_hs = bus.out_valid && bus.out_ready;
      prev_v  = bus.out_valid && !bus.out_ready;
    end
  end
  task automatic send(input logic [7:0] d, input bit gap);
    bit ok = 0;
    if (gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    bus.in_valid = 1; bus.in_data = d;
    for (int k = 0; k < 300; k++) begin @(negedge clk); if (bus.in_ready) begin ok = 1; break; end end
    if (!ok) chk(0, "in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 0; bus.in_data = 8'($urandom);
  endtask
  task automatic send_win(input bit gap);
    for (int i = 0; i < NUM; i++) send(cur[i], gap);
  endtask
  task automatic wait_out(input int n);
    for (int k = 0; k < 2000 && outs < n; k++) @(posedge clk);
    if (outs < n) chk(0, "out_timeout", outs, n);
    #1;
  endtask
  task automatic set_win(input logic [8*NUM-1:0] v);
    for (int i = 0; i < NUM; i++) cur[i] = v[8*(NUM-1-i) +: 8];
  endtask
  initial begin
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk(bus.in_ready, "rst_in_ready", int'(bus.in_ready), 1);
    chk(!bus.out_valid, "rst_out_valid", int'(bus.out_valid), 0);
    chk(bus.out_data == 0, "rst_out_data", int'(bus.out_data), 0);
    @(posedge clk); #1;
    set_win({8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6}); send_win(0); wait_out(1);
    set_win({9{8'hFF}}); send_win(0); wait_out(2);
    set_win({8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255}); send_win(0); wait_out(3);
    set_win({{8{8'h00}}, 8'h80}); send_win(0); wait_out(4);
    set_win({8'hFD, 8'h05, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h02, 8'hFE, 8'h01}); send_win(0); wait_out(5);
    // Back-pressure: hold the result while junk is offered on the input.
    bus.out_ready = 0;
    set_win({8'd5, 8'd1, 8'd9, 8'd3, 8'd7, 8'd2, 8'd8, 8'd4, 8'd6}); send_win(0);
    for (int k = 0; k < 200 && !bus.out_valid; k++) begin @(posedge clk); #1; end
    chk(bus.out_valid, "bp_out_valid", int'(bus.out_valid), 1);
    repeat (20) begin @(posedge clk); #1; bus.in_valid = 1'($urandom_range(0, 1)); bus.in_data = 8'($urandom); end
    bus.in_valid = 0; bus.out_ready = 1; wait_out(6);
    send_win(1); wait_out(7);
    // Reset ten cycles into the sort.
    set_win({8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90}); send_win(0);
    repeat (9) @(posedge clk);
    #1 rst = 1; @(posedge clk); #1 rst = 0;
    repeat (LAT + 20) @(posedge clk);
    chk(outs == 7, "no_out_after_rst", outs, 7);
    #1 set_win({8'd3, 8'd3, 8'd1, 8'd200, 8'd7, 8'd3, 8'd9, 8'd3, 8'd0}); send_win(0); wait_out(8);
    bp_rand = 1;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < NUM; i++) cur[i] = (n % 3 == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      send_win(1'($urandom_range(0, 1))); wait_out(9 + n);
    end
    bp_rand = 0; bus.out_ready = 1;
    repeat (5) @(posedge clk);
    chk(eq.size() == 0, "drained", eq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
